truth_table_driver: RTL and testbench
=====================================

Name: truth_table_driver

Overview:
- Upstream stimulus stage for a 2-input combinational gate under test, such as the NAND network.
- On `start`, drives the gate inputs `a`,`b` through all four truth-table rows in order 00, 01, 10, 11, holding each row for HOLD clock cycles.
- Samples the gate's output at the end of each row and assembles a 4-bit measured truth table.
- Compares the measured table against the expected function and reports `done` and `match`.

Parameters:
- HOLD, 3, number of clock cycles each input row is held; legal range 1..255.
- EXPECTED, 4'b0111, expected truth table; bit index = {a,b}; the default is NAND.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  run request; sampled only in IDLE and DONE.
- gate_out  input  1  output of the gate under test (combinational function of `a`,`b`).
- a  output  1  gate input A (row bit 1).
- b  output  1  gate input B (row bit 0).
- busy  output  1  high while rows are being driven.
- done  output  1  high from run completion until the next accepted start or reset.
- table_out  output  4  measured truth table; bit r = `gate_out` sampled for row r.
- match  output  1  `table_out == EXPECTED`; valid only while `done`=1, 0 otherwise.

Behaviour:
- Reset:
  - One clock and one reset. The reset is synchronous and active-low: `rst_n`=0 at a rising edge of `clk` forces reset state.
  - Reset state: state=IDLE, `a`=0, `b`=0, `busy`=0, `done`=0, `table_out`=4'b0000, `match`=0, row counter 0, hold counter 0.
  - Reset wins over every other event at the same edge, including mid-run and in DONE.
- Counters:
  - Row counter: 2 bits.
  - Hold counter: 8 bits, counts 0..HOLD-1.
- All outputs are registered. `{a,b}` always equals the row counter while in DRIVE, and 00 otherwise.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - `start`=1 at edge k → DRIVE. `table_out` is cleared to 0, row=0, hold=0.
  - From cycle k+1: `busy`=1, `{a,b}`=00.
- DRIVE:
  - Each edge: if hold != HOLD-1 then hold++.
  - Otherwise (last cycle of the row):
    - `table_out[row]` <= `gate_out`, hold <= 0.
    - If row != 3: row++, so the next row appears on `{a,b}` the following cycle.
    - If row == 3: → DONE.
  - Row r is driven during cycles k+1+r*HOLD .. k+(r+1)*HOLD inclusive. `gate_out` is sampled at the edge ending the last of those cycles, giving the gate HOLD-1 full cycles of settle margin.
  - `table_out` fills progressively; bits for unvisited rows stay 0.
- DONE:
  - Entered at edge k+4*HOLD. From cycle k+1+4*HOLD: `busy`=0, `done`=1, `{a,b}`=00, `match`=(`table_out`==EXPECTED).
  - Outputs hold indefinitely.
  - `start`=1 in DONE behaves exactly as in IDLE: `done`→0, `match`→0, `table_out` cleared, DRIVE entered.
- `start` asserted during DRIVE is ignored and not queued.
- `start` held high continuously: the run repeats back-to-back with exactly one DONE cycle between runs.
- HOLD=1: each row lasts one cycle, total `busy` = 4 cycles.
- Run length: `busy` is high for exactly 4*HOLD cycles per run.
- `gate_out` is not synchronised; it must be a combinational function of `a`,`b` in the same clock domain.

Test Plan:
- Ideal NAND model, HOLD=3, 1-cycle `start` pulse at edge 0:
  - `{a,b}` = 00 for cycles 1-3, 01 for 4-6, 10 for 7-9, 11 for 10-12.
  - `done`=1 and `busy`=0 from cycle 13; `table_out`=0111, `match`=1.
- AND model instead of NAND, HOLD=3 → `table_out`=1000, `match`=0, `done`=1 at cycle 13.
- `gate_out` stuck at 1 → `table_out`=1111, `match`=0.
- `start` re-pulsed at cycle 5 during DRIVE → no effect: row sequence and timing are identical to the first scenario.
- `rst_n`=0 at cycle 8 (during row 10), NAND model → from cycle 9: `a`=`b`=0, `busy`=0, `done`=0, `table_out`=0000. A new `start` afterwards completes normally.
- HOLD=1, NAND model → `busy` high for cycles 1-4, `done` at cycle 5, `match`=1.
- Restart from DONE, NAND model:
  - `start` in DONE → next cycle `done`=0, `match`=0, `table_out`=0000.
  - Second run completes with `table_out`=0111, `match`=1.

Source files
------------

// File: rtl/truth_table_driver.sv
// Sweeps {a,b} through rows 00..11 (HOLD cycles each), samples gate_out at each row's last cycle and flags match.
// Latency: done 4*HOLD+1 cycles after the accepting start edge; start is ignored while busy (no queuing).
module truth_table_driver #(
  parameter int         HOLD     = 3,
  parameter logic [3:0] EXPECTED = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic       match
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] row_q,   row_d;
  logic [7:0] hold_q,  hold_d;
  logic [3:0] tbl_q,   tbl_d;
  logic [3:0] tbl_upd;
  logic [1:0] ab_q,    ab_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       match_q, match_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    hold_d  = hold_q;
    tbl_d   = tbl_q;
    ab_d    = 2'b00;
    busy_d  = busy_q;
    done_d  = done_q;
    match_d = match_q;
    tbl_upd = tbl_q;
    tbl_upd[row_q] = gate_out;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          row_d   = 2'd0;
          hold_d  = 8'd0;
          tbl_d   = 4'b0000;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          match_d = 1'b0;
        end
      end
      DRIVE: begin
        ab_d = row_q;
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end else begin
          // last cycle of the row: gate has settled for HOLD-1 cycles
          hold_d = 8'd0;
          tbl_d  = tbl_upd;
          if (row_q != 2'd3) begin
            row_d = row_q + 2'd1;
            ab_d  = row_q + 2'd1;
          end else begin
            state_d = DONE;
            ab_d    = 2'b00;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (tbl_upd == EXPECTED);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      hold_q  <= 8'd0;
      tbl_q   <= 4'b0000;
      ab_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      tbl_q   <= tbl_d;
      ab_q    <= ab_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = tbl_q;
  assign match     = match_q;

endmodule

// File: tb/tb_truth_table_driver.sv
// Drives two driver instances (HOLD=3 and HOLD=1) against a gate defined by a 4-bit function table.
module tb_truth_table_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] func_r;

  logic       a3, b3, busy3, done3, match3, g3;
  logic [3:0] tbl3;
  logic       a1, b1, busy1, done1, match1, g1;
  logic [3:0] tbl1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign g3 = func_r[{a3, b3}];
  assign g1 = func_r[{a1, b1}];

  truth_table_driver #(.HOLD(3), .EXPECTED(4'b0111)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_out(g3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .table_out(tbl3), .match(match3)
  );

  truth_table_driver #(.HOLD(1), .EXPECTED(4'b0111)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_out(g1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .table_out(tbl1), .match(match1)
  );

  // packed observation: {busy, done, match, a, b, table[3:0]}
  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b (busy,done,match,a,b,table)", tag, got, exp);
    end
  endtask

  // Reference: cycle c (c=1 right after the accepting edge) of a run with hold h.
  // With start held, runs repeat every 4h+1 cycles; otherwise the last state persists.
  function automatic logic [8:0] model(input int h, input int c, input logic [3:0] f, input bit held);
    int p;
    logic [3:0] t;
    p = held ? (c - 1) % (4 * h + 1) : ((c - 1) < 4 * h ? (c - 1) : 4 * h);
    if (p < 4 * h) begin
      t = 4'b0000;
      for (int r = 0; r < 4; r++)
        if ((r + 1) * h <= p) t[r] = f[r];
      return {1'b1, 1'b0, 1'b0, 2'(p / h), t};
    end
    return {1'b0, 1'b1, (f == 4'b0111), 2'b00, f};
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_h3"}, {busy3, done3, match3, a3, b3, tbl3}, 9'd0);
    chk({tag, "_h1"}, {busy1, done1, match1, a1, b1, tbl1}, 9'd0);
  endtask

  // Launch a run at the next edge; optionally re-pulse start, hold it, or reset mid-run.
  task automatic run(input logic [3:0] f, input bit held, input int repulse, input int rst_cyc, input int ncyc);
    func_r = f;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (rst_cyc != 0 && c == rst_cyc + 1) begin
        check_reset("mid_rst");
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      chk($sformatf("h3_c%0d", c), {busy3, done3, match3, a3, b3, tbl3}, model(3, c, f, held));
      chk($sformatf("h1_c%0d", c), {busy1, done1, match1, a1, b1, tbl1}, model(1, c, f, held));
      start = held || (c == repulse);
      if (rst_cyc != 0 && c == rst_cyc) rst_n = 1'b0;
    end
    start = 1'b0;
    // drain any run left in flight so both instances sit in IDLE/DONE
    repeat (16) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    func_r = 4'b0111;
    repeat (3) @(negedge clk);
    check_reset("por");
    start = 1'b1;
    @(negedge clk);
    check_reset("start_in_rst");
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);

    run(4'b0111, 1'b0, 0, 0, 15);   // NAND
    run(4'b1000, 1'b0, 0, 0, 15);   // AND, restarts from DONE
    run(4'b1111, 1'b0, 0, 0, 15);   // stuck at 1
    run(4'b0111, 1'b0, 3, 0, 15);   // start re-pulsed mid-drive
    run(4'b0111, 1'b0, 0, 8, 15);   // reset during row 10
    run(4'b0111, 1'b0, 0, 0, 15);   // clean run after reset
    run(4'b0111, 1'b1, 0, 0, 30);   // start held: back-to-back runs

    for (int i = 0; i < 20; i++) begin
      logic [3:0] f;
      int mode;
      f    = 4'($urandom_range(0, 15));
      if (i % 4 == 0) f = 4'b0111;
      mode = $urandom_range(0, 3);
      case (mode)
        0: run(f, 1'b0, 0, 0, 15);
        1: run(f, 1'b0, $urandom_range(1, 3), 0, 15);
        2: run(f, 1'b0, 0, $urandom_range(1, 12), 15);
        default: run(f, 1'b1, 0, 0, 28);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
